// File: rtl/pyld_txseq.sv
// Payload transmit sequencer.
// Times one payload transmission as the segments PYHDR -> BODY -> CRC -> PAD
// and issues one bit request per 1 us bit tick. Each segment appears only when
// the packet needs it.
//
// Ports:
//   clk_6M, rstz                 6 MHz clock, asynchronous active-low reset
//   tx_start, tx_abort, bit_tick control strobes
//   pylenbit, existpyheader,     per-packet length and flags from the decoder;
//   BRss, crcencode, fec32encode sampled on an accepted tx_start
//   busy, seg                    sequencing status (seg is the state register)
//   bit_req, tx_bitcnt           bit requests and the running count of requested bits
//   crc_init, crc_out_en         controls for the CRC unit
//   fec_blk_end                  marks the request that completes a FEC 2/3 block
//   py_done                      pulses when a sequence completes normally
// All outputs are registered. A bit_req and its count update appear together,
// one cycle after the bit_tick that caused them.
module pyld_txseq #(
    parameter int unsigned HDR_SS  = 8,
    parameter int unsigned HDR_MS  = 16,
    parameter int unsigned CRC_LEN = 16,
    parameter int unsigned FEC_BLK = 10
) (
    input  logic        clk_6M,
    input  logic        rstz,
    input  logic        tx_start,
    input  logic        tx_abort,
    input  logic        bit_tick,
    input  logic [12:0] pylenbit,
    input  logic        existpyheader,
    input  logic        BRss,
    input  logic        crcencode,
    input  logic        fec32encode,
    output logic        busy,
    output logic        bit_req,
    output logic [2:0]  seg,
    output logic        crc_init,
    output logic        crc_out_en,
    output logic        fec_blk_end,
    output logic [13:0] tx_bitcnt,
    output logic        py_done
);

    localparam int unsigned LEN_W = 13;
    localparam int unsigned CNT_W = 14;
    localparam int unsigned FEC_W = $clog2(FEC_BLK);

    // The state encoding matches the seg output codes.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PYHDR = 3'd1,
        S_BODY  = 3'd2,
        S_CRC   = 3'd3,
        S_PAD   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state, next_state, tail;
    logic [LEN_W-1:0]   len_q, segcnt, seglen;
    logic               hdr_q, brss_q, crc_q, fec_q;
    logic [FEC_W-1:0]   fec_cnt;
    logic               start_acc, active, req_c, fec_wrap_c, seg_last_c;

    assign seg = state;

    // Next state and per-cycle strobes.
    always_comb begin
        next_state = state;
        tail       = S_DONE;
        start_acc  = 1'b0;
        active     = 1'b0;
        req_c      = 1'b0;
        fec_wrap_c = 1'b0;
        seg_last_c = 1'b0;
        seglen     = LEN_W'(1);

        case (state)
            S_PYHDR: seglen = brss_q ? LEN_W'(HDR_SS) : LEN_W'(HDR_MS);
            S_BODY:  seglen = len_q;
            S_CRC:   seglen = LEN_W'(CRC_LEN);
            default: seglen = LEN_W'(1);
        endcase

        active = (state == S_PYHDR) || (state == S_BODY) ||
                 (state == S_CRC)   || (state == S_PAD);
        // No request in the crc_init cycle, so the CRC seed is in place first.
        req_c      = bit_tick & active & ~crc_init & ~tx_abort;
        fec_wrap_c = req_c & fec_q & (fec_cnt == FEC_W'(FEC_BLK - 1));
        seg_last_c = req_c & ((state == S_PAD) ? fec_wrap_c
                                               : (segcnt == seglen - LEN_W'(1)));
        // After the last data/CRC bit, pad only if that bit leaves a partial FEC block.
        tail = (fec_q & ~fec_wrap_c) ? S_PAD : S_DONE;

        if (tx_abort) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tx_start) begin
                        start_acc  = 1'b1;
                        next_state = existpyheader          ? S_PYHDR :
                                     (pylenbit != '0)       ? S_BODY  :
                                     crcencode              ? S_CRC   : S_DONE;
                    end
                end
                S_PYHDR: if (seg_last_c) next_state = (len_q != '0) ? S_BODY :
                                                      crc_q         ? S_CRC  : tail;
                S_BODY:  if (seg_last_c) next_state = crc_q ? S_CRC : tail;
                S_CRC:   if (seg_last_c) next_state = tail;
                S_PAD:   if (seg_last_c) next_state = S_DONE;
                S_DONE:  next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) state <= S_IDLE;
        else       state <= next_state;
    end

    // Latched packet parameters, counters and registered outputs.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            len_q       <= '0;
            hdr_q       <= 1'b0;
            brss_q      <= 1'b0;
            crc_q       <= 1'b0;
            fec_q       <= 1'b0;
            segcnt      <= '0;
            fec_cnt     <= '0;
            tx_bitcnt   <= '0;
            bit_req     <= 1'b0;
            fec_blk_end <= 1'b0;
            crc_init    <= 1'b0;
            crc_out_en  <= 1'b0;
            busy        <= 1'b0;
            py_done     <= 1'b0;
        end else begin
            if (start_acc) begin
                len_q     <= pylenbit;
                hdr_q     <= existpyheader;
                brss_q    <= BRss;
                crc_q     <= crcencode;
                fec_q     <= fec32encode;
                segcnt    <= '0;
                fec_cnt   <= '0;
                tx_bitcnt <= '0;
            end else if (req_c) begin
                tx_bitcnt <= tx_bitcnt + CNT_W'(1);
                segcnt    <= seg_last_c ? '0 : segcnt + LEN_W'(1);
                if (fec_q) fec_cnt <= fec_wrap_c ? '0 : fec_cnt + FEC_W'(1);
            end else if (tx_abort) begin
                // tx_bitcnt keeps the aborted packet's count until the next start.
                segcnt  <= '0;
                fec_cnt <= '0;
            end
            bit_req     <= req_c;
            fec_blk_end <= fec_wrap_c;
            crc_init    <= start_acc;
            crc_out_en  <= (next_state == S_CRC);
            busy        <= (next_state != S_IDLE);
            py_done     <= (state == S_DONE) & ~tx_abort;
        end
    end

endmodule
